// File: rtl/pic_scanner_pkg.sv
// Shared constants, FSM encoding and stream beat layout
// for the picture RAM scanner.
package pic_scanner_pkg;

    localparam int NUM_PIX = 784;
    localparam int ROW_LEN = 28;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int COL_W   = $clog2(ROW_LEN);
    localparam int BEAT_W  = DATA_W + ADDR_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] idx;
        logic              row_end;
        logic              last;
    } beat_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry FIFO holding tagged pixel beats;
// the head entry drives the stream outputs directly.
module pix_fifo2 #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/pic_scanner.sv
// Scans the 28x28 picture RAM and streams pixels with
// row-end/last markers under valid/ready backpressure.
module pic_scanner
    import pic_scanner_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] pix_idx,
    output logic              pix_row_end,
    output logic              pix_last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ROW_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] issue_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [COL_W-1:0]  col;
    logic              inflight;
    logic [ADDR_W-1:0] tag_idx;
    logic              tag_row_end;
    logic              tag_last;

    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [BEAT_W-1:0] fifo_dout;
    beat_t             push_beat;
    beat_t             head;
    logic              pop;
    logic [2:0]        occ;
    logic              issue;

    assign pop   = !fifo_empty && pix_ready;
    // Slots already claimed once this cycle's pop retires.
    assign occ   = {2'b0, inflight} + {1'b0, fifo_count} - {2'b0, pop};
    assign issue = (state == RUN) && (occ < 3'd2) && !(fifo_full && !pop);

    assign ram_addr = issue ? issue_cnt : last_addr;

    always_comb begin
        push_beat         = '0;
        push_beat.data    = ram_data;
        push_beat.idx     = tag_idx;
        push_beat.row_end = tag_row_end;
        push_beat.last    = tag_last;
    end

    pix_fifo2 #(.W(BEAT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (push_beat),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head        = beat_t'(fifo_dout);
    assign pix_data    = head.data;
    assign pix_idx     = head.idx;
    assign pix_row_end = head.row_end;
    assign pix_last    = head.last;
    assign pix_valid   = !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            last_addr   <= '0;
            col         <= '0;
            inflight    <= 1'b0;
            tag_idx     <= '0;
            tag_row_end <= 1'b0;
            tag_last    <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (state == IDLE && start) begin
                issue_cnt <= '0;
                col       <= '0;
            end else if (issue) begin
                last_addr   <= issue_cnt;
                issue_cnt   <= issue_cnt + 1'b1;
                col         <= (col == COL_LAST) ? '0 : col + 1'b1;
                tag_idx     <= issue_cnt;
                tag_row_end <= (col == COL_LAST);
                tag_last    <= (issue_cnt == LAST_IDX);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (issue && issue_cnt == LAST_IDX) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave as soon as the final beat is handed off.
                if (!inflight &&
                    (fifo_empty || (fifo_count == 2'd1 && pop)))
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
